ping: RTL and testbench

- Ping-pong spectrum buffer on the channel side of the dual-channel FFT upload path.
- Write side: captures one frame of DEPTH accumulated FFT words per channel.
- Read side: answers the single-cycle `upload_start` pulse from the upload switcher with a contiguous DEPTH-word burst on `data_out`/`data_valid`.
- One instance per channel; both outputs feed the switcher's `data_in_1/2` and `data_valid_i1/2`.

---
 rtl/upload_pkg.sv | 25 ++
 rtl/ping_if.sv | 34 +++
 rtl/upload_dpram.sv | 44 ++++
 rtl/ping.sv | 173 +++++++++++++++++
 tb/tb_ping.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/upload_pkg.sv
// upload_pkg: shared definitions for the ping-pong spectrum upload buffer.
//   DEPTH_DEFAULT  - default words per frame / burst (power of two)
//   DATA_W_DEFAULT - default word width
//   rd_state_t     - read-side FSM states (IDLE/HDR/READ/DRAIN)
//   HDR_MAGIC      - magic tag in the optional burst header word
//   sat_inc16      - saturating 16-bit increment for the miss counter
package upload_pkg;

  localparam int DEPTH_DEFAULT  = 512;
  localparam int DATA_W_DEFAULT = 64;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ping_if.sv
// ping_if: bundle of the write-side and upload-side signals of one
// spectrum upload buffer channel.
//   master modport: accumulator/switcher side (drives wr_*, frame_done,
//                   upload_start; observes burst outputs and status)
//   slave modport : buffer side (the ping module)
//   Signals: wr_en, wr_data, frame_done, upload_start (to buffer);
//            data_out, data_valid, busy, frame_err, miss_cnt (from buffer)
interface ping_if
  import upload_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              upload_start;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic [15:0]       miss_cnt;

  modport master (
    output wr_en, wr_data, frame_done, upload_start,
    input  data_out, data_valid, busy, frame_err, miss_cnt
  );

  modport slave (
    input  wr_en, wr_data, frame_done, upload_start,
    output data_out, data_valid, busy, frame_err, miss_cnt
  );

endinterface

// File: rtl/upload_dpram.sv
// upload_dpram: simple dual-port RAM holding both ping-pong banks
// (2*DEPTH x DATA_W). Address is {bank, index}.
//   clk, rst          - clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   - write port
//   rd_en/rd_addr     - read request; rd_data is registered (1-cycle latency)
//                       and forced to 0 on cycles with no read
module upload_dpram
  import upload_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register doubles as the burst data register, so it reads as
  // zero whenever no word is being read out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/ping.sv
// ping: ping-pong spectrum upload buffer for one FFT channel.
// Captures DEPTH-word frames into the write bank and, on upload_start,
// bursts the last published frame out of the other bank.
//   clk, rst - clock, synchronous active-high reset
//   bus      - ping_if.slave: wr_en/wr_data/frame_done (write side),
//              upload_start (burst request), data_out/data_valid (burst),
//              busy, frame_err (discarded frame pulse), miss_cnt
// Optional feature: define UPLOAD_HEADER_EN to prefix every burst with a
// header word {16'hA55A, 16'd0, 32-bit published-frame sequence number}.
module ping
  import upload_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int AW     = $clog2(DEPTH)
) (
  input logic   clk,
  input logic   rst,
  ping_if.slave bus
);

  logic              wb;
  logic [AW:0]       wr_cnt;
  logic              wr_drop;
  logic              frame_err_q;

  rd_state_t         state;
  logic              rdy;
  logic              rd_bank;
  logic [AW-1:0]     rd_idx;
  logic              data_valid_q;
  logic [15:0]       miss_q;
  logic [DATA_W-1:0] ram_q;

  logic              wr_fits;
  logic              wr_take;
  logic [AW:0]       frame_len;
  logic              frame_good;
  logic              start_ok;
  logic              reading;
  logic              publish;

  assign wr_fits    = wr_cnt < (AW+1)'(DEPTH);
  assign wr_take    = bus.wr_en && wr_fits;
  // A word arriving together with frame_done is the frame's last word.
  assign frame_len  = wr_cnt + (AW+1)'(wr_take);
  assign frame_good = (frame_len == (AW+1)'(DEPTH)) && !wr_drop &&
                      !(bus.wr_en && !wr_fits);
  assign start_ok   = bus.upload_start && (state == IDLE) && rdy;
  // A burst accepted this cycle already owns the published bank, so a frame
  // finishing in the same cycle must not flip the banks under it.
  assign reading    = (state != IDLE) || start_ok;
  assign publish    = bus.frame_done && frame_good && !reading;

`ifdef UPLOAD_HEADER_EN
  logic [31:0]       seq_q;
  logic [DATA_W-1:0] hdr_q;
`endif

  // Write side: fill the write bank, drop overflow words, and on
  // frame_done either publish (flip banks) or flag the frame as lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb          <= 1'b0;
      wr_cnt      <= '0;
      wr_drop     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UPLOAD_HEADER_EN
      seq_q       <= '0;
`endif
    end else begin
      frame_err_q <= bus.frame_done && !publish;
      if (bus.frame_done) begin
        wr_cnt  <= '0;
        wr_drop <= 1'b0;
        if (publish) begin
          wb <= ~wb;
`ifdef UPLOAD_HEADER_EN
          seq_q <= seq_q + 32'd1;
`endif
        end
      end else if (wr_take) begin
        wr_cnt <= wr_cnt + (AW+1)'(1);
      end else if (bus.wr_en) begin
        wr_drop <= 1'b1;
      end
    end
  end

  // Read FSM: accepts a start only when idle with an unread frame, walks
  // the latched bank one word per cycle, then drains the RAM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rdy          <= 1'b0;
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      data_valid_q <= 1'b0;
      miss_q       <= '0;
`ifdef UPLOAD_HEADER_EN
      hdr_q        <= '0;
`endif
    end else begin
`ifdef UPLOAD_HEADER_EN
      data_valid_q <= (state == READ) || (state == HDR);
      hdr_q        <= (state == HDR) ? DATA_W'({HDR_MAGIC, 16'd0, seq_q}) : '0;
`else
      data_valid_q <= (state == READ);
`endif
      if (publish) begin
        rdy <= 1'b1;
      end else if (start_ok) begin
        rdy <= 1'b0;
      end
      if (bus.upload_start && !start_ok) begin
        miss_q <= sat_inc16(miss_q);
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            rd_bank <= ~wb;
            rd_idx  <= '0;
`ifdef UPLOAD_HEADER_EN
            state   <= HDR;
`else
            state   <= READ;
`endif
          end
        end
        HDR: begin
          state <= READ;
        end
        READ: begin
          rd_idx <= rd_idx + AW'(1);
          if (rd_idx == AW'(DEPTH - 1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  upload_dpram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_take),
    .wr_addr ({wb, wr_cnt[AW-1:0]}),
    .wr_data (bus.wr_data),
    .rd_en   (state == READ),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (ram_q)
  );

`ifdef UPLOAD_HEADER_EN
  assign bus.data_out = ram_q | hdr_q;
`else
  assign bus.data_out = ram_q;
`endif
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_err  = frame_err_q;
  assign bus.miss_cnt   = miss_q;

endmodule

// File: tb/tb_ping.sv
// tb_ping: self-checking bench for the ping spectrum upload buffer.
// Keeps a frame-level model (last published frame, ready flag, reader busy
// window, miss count, sequence number) and checks bursts cycle by cycle.
// Honours UPLOAD_HEADER_EN for the expected header word and burst length.
module tb_ping;
  import upload_pkg::*;

  localparam int D  = DEPTH_DEFAULT;
  localparam int DW = DATA_W_DEFAULT;
`ifdef UPLOAD_HEADER_EN
  localparam int HL = 1;
`else
  localparam int HL = 0;
`endif
  localparam int BLEN = D + HL;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ping_if #(.DATA_W(DW)) bus ();

  ping #(.DEPTH(D), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Frame-level reference model
  logic [DW-1:0] pub_q[$];
  bit            model_rdy = 0;
  logic [31:0]   model_seq = 0;
  int            model_miss = 0;
  int            burst_edge = -100000;

  // The reader is busy with a burst accepted at burst_edge for the edges
  // after it, up to the edge where busy drops.
  function automatic bit rd_active(input int e);
    return (e > burst_edge) && (e <= burst_edge + BLEN + 1);
  endfunction

  task automatic model_reset();
    model_rdy  = 0;
    model_seq  = 0;
    model_miss = 0;
    burst_edge = -100000;
  endtask

  // Writes n words (counting or random data), optional idle gaps, with
  // frame_done on the last word or on a separate following cycle.
  task automatic write_frame(input int n, input bit gaps, input bit sep, input bit count_data);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    int e;
    bit pub;
    words = {};
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.frame_done = 1'b0;
      end
      @(negedge clk);
      w = count_data ? DW'(i) : DW'({$urandom, $urandom});
      bus.wr_en = 1'b1;
      bus.wr_data = w;
      bus.frame_done = !sep && (i == n - 1);
      if (i < D) words.push_back(w);
    end
    if (sep) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.frame_done = 1'b1;
    end
    e = edge_cnt + 1;
    pub = (n == D) && !rd_active(e);
    if (pub) begin
      pub_q = words;
      model_rdy = 1;
      model_seq = model_seq + 32'd1;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.frame_done = 1'b0;
    vectors++;
    if (bus.frame_err !== 1'(!pub)) begin
      miscompares++;
      $display("[TB] FAIL frame_err after %0d-word frame: got %b, expected %b", n, bus.frame_err, !pub);
    end
    @(negedge clk);
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL frame_err width (%0d-word frame): got %b, expected 0", n, bus.frame_err);
    end
  endtask

  // Pulses upload_start after 'delay' idle cycles and checks every cycle.
  // mode 1: extra upload_start at cycle kk; mode 2: reset while word kk shows.
  task automatic run_burst(input int delay, input int mode, input int kk);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    logic exp_valid, exp_busy;
    int e, kstop;
    bit acc;
    repeat (delay) @(negedge clk);
    @(negedge clk);
    e = edge_cnt + 1;
    acc = model_rdy && !rd_active(e);
    exp_q = {};
    if (acc) begin
      if (HL == 1) exp_q.push_back(DW'({HDR_MAGIC, 16'd0, model_seq}));
      foreach (pub_q[i]) exp_q.push_back(pub_q[i]);
      model_rdy = 0;
      burst_edge = e;
    end else if (model_miss < 65535) begin
      model_miss++;
    end
    bus.upload_start = 1'b1;
    kstop = (mode == 2) ? kk + 2 + HL : BLEN + 2;
    for (int k = 1; k <= kstop; k++) begin
      @(negedge clk);
      bus.upload_start = 1'b0;
      exp_valid = acc && (k >= 2) && (k <= BLEN + 1);
      exp_busy  = acc && (k >= 1) && (k <= BLEN + 1);
      exp_data  = exp_valid ? exp_q[k-2] : '0;
      vectors++;
      if ({bus.busy, bus.data_valid, bus.data_out} !== {exp_busy, exp_valid, exp_data}) begin
        miscompares++;
        $display("[TB] FAIL burst cycle T+%0d busy/valid/data: got %b/%b/%h, expected %b/%b/%h",
                 k, bus.busy, bus.data_valid, bus.data_out, exp_busy, exp_valid, exp_data);
      end
      if (mode == 1 && k == kk) begin
        bus.upload_start = 1'b1;
        model_miss++;
      end
    end
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.data_valid, bus.data_out, bus.frame_err, bus.miss_cnt} !== {2'b00, DW'(0), 1'b0, 16'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset mid-burst busy/valid/data/err/miss: got %b/%b/%h/%b/%0d, expected 0/0/0/0/0",
                 bus.busy, bus.data_valid, bus.data_out, bus.frame_err, bus.miss_cnt);
      end
      rst = 1'b0;
      model_reset();
    end else begin
      vectors++;
      if (bus.miss_cnt !== 16'(model_miss)) begin
        miscompares++;
        $display("[TB] FAIL miss_cnt after burst: got %0d, expected %0d", bus.miss_cnt, model_miss);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.data_out !== DW'(0)) begin
      miscompares++;
      $display("[TB] FAIL reset data_out: got %h, expected 0", bus.data_out);
    end
    vectors++;
    if ({bus.data_valid, bus.busy, bus.frame_err} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset valid/busy/err: got %b%b%b, expected 000", bus.data_valid, bus.busy, bus.frame_err);
    end
    vectors++;
    if (bus.miss_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset miss_cnt: got %0d, expected 0", bus.miss_cnt);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_no_frame();
    run_burst(1, 0, 0);
  endtask

  task automatic test_normal();
    write_frame(D, 0, 0, 1);
    run_burst(2, 1, 100);
  endtask

  task automatic test_bad_frames();
    write_frame(D, 1, 1, 0);
    write_frame(500, 0, 0, 0);
    write_frame(520, 1, 0, 0);
    run_burst(0, 0, 0);
    run_burst(1, 0, 0);
  endtask

  task automatic test_back_to_back();
    write_frame(D, 1, 0, 0);
    fork
      run_burst(5, 0, 0);
      write_frame(D, 0, 0, 0);
    join
    write_frame(D, 1, 1, 0);
    run_burst(0, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    write_frame(D, 1, 0, 0);
    run_burst(0, 2, 100);
    run_burst(1, 0, 0);
    write_frame(D, 0, 1, 0);
    write_frame(D, 1, 0, 0);
    run_burst(2, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.frame_done = 1'b0;
    bus.upload_start = 1'b0;
    test_reset();
    test_no_frame();
    test_normal();
    test_bad_frames();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
